ram_burst_writer: RTL and testbench
===================================

Name: ram_burst_writer

Overview:
- Write-side counterpart of the team's 16x4 lookup memories: holds an internal DEPTH x WIDTH array and fills it from a valid/ready word stream, in bursts starting at a programmable base address.
- An asynchronous read port (rd_addr -> q, unregistered) serves table consumers.
- Lets a controller load lookup contents at run time instead of from a fixed init file.

Parameters:
- WIDTH, 4, data word width in bits.
- AW, 4, address width; DEPTH = 2**AW words.

Ports:
- inclk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a burst; ignored unless in IDLE.
- base_addr  in  AW  first write address; sampled when start is accepted.
- count  in  AW+1  burst length, 0..DEPTH; sampled when start is accepted.
- din  in  WIDTH  write data word.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  block will accept din this cycle.
- busy  out  1  high in the WRITE state.
- done  out  1  one-cycle pulse when a burst completes.
- rd_addr  in  AW  read address.
- q  out  WIDTH  mem[rd_addr], combinational (unregistered).

Behaviour:
- Reset values: state=IDLE, din_ready=0, busy=0, done=0, wr_ptr=0, remaining=0.
- rst does not clear the memory array; mem contents are undefined until written.
- Interface: one clock, inclk; reset rst is synchronous and active-high.
- FSM states are IDLE, WRITE and DONE.
- IDLE:
  - start=1 and count!=0 -> latch wr_ptr=base_addr, remaining=count; go to WRITE next cycle.
  - start=1 and count==0 -> go to DONE directly; no writes.
- WRITE:
  - busy=1; din_ready=1, registered, asserted the cycle after entry.
  - A transfer occurs on a cycle with din_valid & din_ready: mem[wr_ptr]<=din, wr_ptr<=wr_ptr+1 mod DEPTH, remaining<=remaining-1.
  - On the transfer with remaining==1: go to DONE; din_ready drops the next cycle.
  - din_valid=0 stalls with no state change; no timeout.
- DONE: done=1 for exactly one cycle; busy=0; din_ready=0; returns to IDLE.
- Throughput: one word per cycle, back-to-back.
- Latency: start accepted at edge N -> din_ready=1 from cycle N+1. The last transfer at edge M gives done=1 in cycle M+1.
- Wrap-around: writes past DEPTH-1 continue at 0.
  - count=DEPTH with base_addr!=0 overwrites the whole array exactly once.
- start while in WRITE or DONE: ignored, no effect on the current burst.
- Read/write collision (rd_addr == wr_ptr on a write edge): q shows old data before the edge and new data after it. There is no bypass.
- rst asserted mid-burst: next state IDLE, din_ready=0 and busy=0 from the following cycle, no done pulse. Words already written remain in memory.
- din_ready never depends combinationally on din_valid.

Optional Feature:
- Macro: RAM_BURST_WRITER_CHECKSUM_EN.
- With it defined:
  - Adds output csum (WIDTH bits): XOR of all words accepted in the current burst.
  - csum is cleared to 0 when start is accepted and on rst.
  - It updates on each transfer and holds its value after done until the next accepted start.
- Without it: no csum port and no checksum logic.

Test Plan:
- Reset, then start with base_addr=0, count=16, din=0..15 streamed with din_valid held high -> din_ready high for 16 consecutive cycles, done pulses once, q reads mem[i]=i for all rd_addr.
- Wrap: base_addr=14, count=4, din=A,B,C,D -> mem[14]=A, mem[15]=B, mem[0]=C, mem[1]=D; other locations unchanged.
- Stalls: count=3 with din_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, busy high throughout, done one cycle after the 3rd accepted word.
- count=0 start -> no din_ready, done pulses once 1 cycle after start, memory unchanged. A start issued during WRITE is ignored.
- rst mid-burst, after 2 of 5 words -> busy=0 and din_ready=0 next cycle, no done pulse, first 2 words present. A subsequent burst works normally.
- With CHECKSUM_EN: burst 1,2,4,8 -> csum=0xF after done; the next start clears csum to 0.

Source files
------------

// File: rtl/ram_burst_writer_if.sv
// Write-stream, control and read-port bundle for ram_burst_writer.
// With RAM_BURST_WRITER_CHECKSUM_EN defined, the bundle also carries csum.
interface ram_burst_writer_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 4
);
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             busy;
    logic             done;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] q;
`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    logic [WIDTH-1:0] csum;

    modport master (
        output start, base_addr, count, din, din_valid, rd_addr,
        input  din_ready, busy, done, q, csum
    );
    modport slave (
        input  start, base_addr, count, din, din_valid, rd_addr,
        output din_ready, busy, done, q, csum
    );
`else
    modport master (
        output start, base_addr, count, din, din_valid, rd_addr,
        input  din_ready, busy, done, q
    );
    modport slave (
        input  start, base_addr, count, din, din_valid, rd_addr,
        output din_ready, busy, done, q
    );
`endif
endinterface

// File: rtl/ram_burst_writer.sv
// Fills a DEPTH x WIDTH lookup array from a valid/ready word stream in bursts.
// Optional burst XOR checksum on bus.csum: define RAM_BURST_WRITER_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; base_addr/count latched on accept
// S_WRITE | accepting words, one per cycle, until remaining reaches 0
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module ram_burst_writer #(
    parameter int WIDTH = 4,
    parameter int AW    = 4
) (
    input  logic                 inclk,
    input  logic                 rst,
    ram_burst_writer_if.slave    bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rem_q, rem_d;
    logic             ready_q, ready_d;
    logic             xfer;
    logic             start_ok;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge inclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rem_q    <= rem_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rem_d    = rem_q;
        xfer     = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    start_ok = 1'b1;
                    if (bus.count != '0) begin
                        wr_ptr_d = bus.base_addr;
                        rem_d    = bus.count;
                        state_d  = S_WRITE;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (ready_q && bus.din_valid) begin
                    xfer     = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    if (rem_q == {{AW{1'b0}}, 1'b1}) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered ready follows the next state so it is high from the first WRITE cycle.
        ready_d = (state_d == S_WRITE);
    end

    // The array has no reset: contents survive rst and are undefined until written.
    always_ff @(posedge inclk) begin
        if (xfer) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.din_ready = ready_q;
    assign bus.busy      = (state_q == S_WRITE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.q         = mem[bus.rd_addr];

`ifdef RAM_BURST_WRITER_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q;

    always_ff @(posedge inclk) begin
        if (rst || start_ok) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q ^ bus.din;
        end
    end

    assign bus.csum = csum_q;
`endif
endmodule

// File: tb/tb_ram_burst_writer.sv
// Directed bench for ram_burst_writer: per-cycle vector table plus corner-case sequences.
module tb_ram_burst_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ram_burst_writer_if #(.WIDTH(4), .AW(4)) ifc ();

    ram_burst_writer #(.WIDTH(4), .AW(4)) dut (
        .inclk (clk),
        .rst   (rst),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic       start;
        logic [3:0] base;
        logic [4:0] cnt;
        logic [3:0] din;
        logic       valid;
        logic       er;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t       vecs [19];
    logic [3:0] fin  [16];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive inputs, compare this cycle's outputs, then advance past the edge.
    task automatic cyc(input string nm, input logic st, input logic [3:0] base,
                       input logic [4:0] cnt, input logic [3:0] din, input logic valid,
                       input logic er, input logic eb, input logic ed);
        ifc.start     = st;
        ifc.base_addr = base;
        ifc.count     = cnt;
        ifc.din       = din;
        ifc.din_valid = valid;
        check({nm, ".ready"}, {7'd0, ifc.din_ready}, {7'd0, er});
        check({nm, ".busy"},  {7'd0, ifc.busy},      {7'd0, eb});
        check({nm, ".done"},  {7'd0, ifc.done},      {7'd0, ed});
        sync();
    endtask

    task automatic check_q(input string nm, input logic [3:0] a, input logic [3:0] e);
        ifc.rd_addr = a;
        #1;
        check(nm, {4'd0, ifc.q}, {4'd0, e});
    endtask

    initial begin
        // Full 16-word burst from address 0, valid held high.
        vecs[0] = '{1'b1, 4'd0, 5'd16, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i <= 16; i++)
            vecs[i] = '{1'b0, 4'd0, 5'd0, 4'(i - 1), 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        fin = '{4'hC, 4'hD, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'h7,
                4'h5, 4'h6, 4'h1, 4'h2, 4'hE, 4'hD, 4'hA, 4'hB};

        ifc.start = 1'b0; ifc.base_addr = '0; ifc.count = '0;
        ifc.din = '0; ifc.din_valid = 1'b0; ifc.rd_addr = '0;
        rst = 1'b1;
        sync(); sync();
        rst = 1'b0;
        check("reset.ready", {7'd0, ifc.din_ready}, 8'd0);
        check("reset.busy",  {7'd0, ifc.busy},      8'd0);
        check("reset.done",  {7'd0, ifc.done},      8'd0);
        sync();

        for (int i = 0; i < 19; i++)
            cyc($sformatf("burst16[%0d]", i), vecs[i].start, vecs[i].base, vecs[i].cnt,
                vecs[i].din, vecs[i].valid, vecs[i].er, vecs[i].eb, vecs[i].ed);
        for (int i = 0; i < 16; i++)
            check_q($sformatf("burst16.q[%0d]", i), 4'(i), 4'(i));
        sync();

        // Wrap past the top of the array.
        cyc("wrap0", 1'b1, 4'd14, 5'd4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("wrap1", 1'b0, 4'd0,  5'd0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("wrap2", 1'b0, 4'd0,  5'd0, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("wrap3", 1'b0, 4'd0,  5'd0, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("wrap4", 1'b0, 4'd0,  5'd0, 4'hD, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("wrap5", 1'b0, 4'd0,  5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_q("wrap.q14", 4'd14, 4'hA);
        check_q("wrap.q15", 4'd15, 4'hB);
        check_q("wrap.q0",  4'd0,  4'hC);
        check_q("wrap.q1",  4'd1,  4'hD);
        check_q("wrap.q2",  4'd2,  4'h2);
        check_q("wrap.q13", 4'd13, 4'hD);
        sync();

        // Stalls: valid pattern 1,0,0,1,0,1.
        cyc("stall0", 1'b1, 4'd4, 5'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("stall1", 1'b0, 4'd0, 5'd0, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("stall2", 1'b0, 4'd0, 5'd0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("stall3", 1'b0, 4'd0, 5'd0, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("stall4", 1'b0, 4'd0, 5'd0, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("stall5", 1'b0, 4'd0, 5'd0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("stall6", 1'b0, 4'd0, 5'd0, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("stall7", 1'b0, 4'd0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("stall8", 1'b0, 4'd0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_q("stall.q3", 4'd3, 4'h3);
        check_q("stall.q4", 4'd4, 4'h7);
        check_q("stall.q5", 4'd5, 4'h8);
        check_q("stall.q6", 4'd6, 4'h9);
        check_q("stall.q7", 4'd7, 4'h7);
        sync();

        // Zero-length burst: straight to DONE, valid high but nothing written.
        cyc("zero0", 1'b1, 4'd2, 5'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("zero1", 1'b0, 4'd0, 5'd0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("zero2", 1'b0, 4'd0, 5'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        check_q("zero.q2", 4'd2, 4'h2);
        sync();

        // start during WRITE must not reload base/count.
        cyc("restart0", 1'b1, 4'd8, 5'd2,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("restart1", 1'b1, 4'd0, 5'd5,  4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("restart2", 1'b1, 4'd0, 5'd5,  4'h6, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("restart3", 1'b1, 4'd0, 5'd16, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("restart4", 1'b0, 4'd0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_q("restart.q8",  4'd8,  4'h5);
        check_q("restart.q9",  4'd9,  4'h6);
        check_q("restart.q10", 4'd10, 4'hA);
        check_q("restart.q0",  4'd0,  4'hC);
        sync();

        // Reset after 2 of 5 words.
        cyc("rst0", 1'b1, 4'd10, 5'd5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst1", 1'b0, 4'd0,  5'd0, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("rst2", 1'b0, 4'd0,  5'd0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("rst3", 1'b0, 4'd0,  5'd0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        cyc("rst4", 1'b0, 4'd0,  5'd0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rst5", 1'b0, 4'd0,  5'd0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        check_q("rst.q10", 4'd10, 4'h1);
        check_q("rst.q11", 4'd11, 4'h2);
        check_q("rst.q12", 4'd12, 4'hC);
        sync();

        // Single-word burst after reset, with read/write collision at address 12.
        ifc.rd_addr = 4'd12;
        cyc("post0", 1'b1, 4'd12, 5'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("collide.before", {4'd0, ifc.q}, 8'h0C);
        cyc("post1", 1'b0, 4'd0,  5'd0, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0);
        check("collide.after", {4'd0, ifc.q}, 8'h0E);
        cyc("post2", 1'b0, 4'd0,  5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++)
            check_q($sformatf("final.q[%0d]", i), 4'(i), fin[i]);
        sync();

`ifdef RAM_BURST_WRITER_CHECKSUM_EN
        cyc("cs0", 1'b1, 4'd0, 5'd4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cs.cleared", {4'd0, ifc.csum}, 8'h00);
        cyc("cs1", 1'b0, 4'd0, 5'd0, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("cs.after1", {4'd0, ifc.csum}, 8'h01);
        cyc("cs2", 1'b0, 4'd0, 5'd0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("cs3", 1'b0, 4'd0, 5'd0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("cs4", 1'b0, 4'd0, 5'd0, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0);
        check("cs.done", {4'd0, ifc.csum}, 8'h0F);
        cyc("cs5", 1'b0, 4'd0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("cs.hold", {4'd0, ifc.csum}, 8'h0F);
        cyc("cs6", 1'b1, 4'd0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cs.restart", {4'd0, ifc.csum}, 8'h00);
        cyc("cs7", 1'b0, 4'd0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
